// File: rtl/pcseq_pkg.sv
// Shared definitions for the sequential popcount neuron.
//   CHUNK_W   : width of one popcount slice
//   state_t   : controller states
//   TRIT_*    : encodings of the ternary result on out_trit
package pcseq_pkg;

   localparam int CHUNK_W = 18;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      POS  = 2'd1,
      NEG  = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic [1:0] TRIT_POS  = 2'b01;
   localparam logic [1:0] TRIT_NEG  = 2'b11;
   localparam logic [1:0] TRIT_ZERO = 2'b00;

endpackage

// File: rtl/popcount18_unit.sv
// Combinational 18-bit population count.
//   i_bits  : 18-bit input slice
//   o_count : number of ones in i_bits (0..18)
// Exact implementation; an approximate netlist with identical ports can
// replace it without touching the controller.
module popcount18_unit (
   input  logic [17:0] i_bits,
   output logic [4:0]  o_count
);

   always_comb begin
      o_count = 5'd0;
      for (int i = 0; i < 18; i++) begin
         o_count = o_count + {4'd0, i_bits[i]};
      end
   end

endmodule

// File: rtl/popcount_seq_neuron.sv
// Sequential ternary neuron: one popcount18 engine is stepped over the
// captured input masks, 18 bits per cycle, chunk 0 first. The signed
// sum pc(pos) - pc(neg) is thresholded into a trit and held on a
// valid/ready output until taken.
//
// Build option NEURON_TERNARY_EN:
//   defined   : POS then NEG pass, trit in {+1, 0, -1}
//   undefined : POS pass only, in_neg/thr_neg ignored, trit in {+1, 0}
//
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : input handshake
//   in_pos, in_neg      : positive / negative activation masks (F bits)
//   thr_pos, thr_neg    : unsigned thresholds
//   out_valid/out_ready : output handshake
//   out_sum             : signed accumulated sum
//   out_trit            : 01 = +1, 11 = -1, 00 = 0
//
// state | meaning
// IDLE  | ready for a vector, in_ready=1
// POS   | accumulating popcount of in_pos chunks
// NEG   | subtracting popcount of in_neg chunks
// DONE  | result held, out_valid=1 until out_ready
module popcount_seq_neuron
   import pcseq_pkg::*;
#(
   parameter  int N_CHUNKS = 4,
   localparam int F        = CHUNK_W * N_CHUNKS,
   localparam int ACC_W    = $clog2(F + 1)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [F-1:0]            in_pos,
   input  logic [F-1:0]            in_neg,
   input  logic [ACC_W-1:0]        thr_pos,
   input  logic [ACC_W-1:0]        thr_neg,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [ACC_W:0]   out_sum,
   output logic [1:0]              out_trit
);

   localparam int IDX_W = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;

   state_t                  r_state;
   logic [F-1:0]            r_pos;
   logic [ACC_W-1:0]        r_thr_pos;
   logic signed [ACC_W:0]   r_acc;
   logic [IDX_W-1:0]        r_idx;
   logic                    r_in_ready;
   logic                    r_out_valid;
   logic signed [ACC_W:0]   r_out_sum;
   logic [1:0]              r_out_trit;

   logic [CHUNK_W-1:0]      w_chunk;
   logic [4:0]              w_pc;
   logic signed [ACC_W:0]   w_pc_ext;
   logic signed [ACC_W:0]   w_acc_next;
   logic                    w_last;
   logic [1:0]              w_trit;

`ifdef NEURON_TERNARY_EN
   logic [F-1:0]            r_neg;
   logic [ACC_W-1:0]        r_thr_neg;
   logic signed [ACC_W:0]   w_neg_lim;
`else
   logic                    w_unused_neg;
   assign w_unused_neg = ^{in_neg, thr_neg};
`endif

   assign w_last = (r_idx == IDX_W'(N_CHUNKS - 1));

   always_comb begin
      w_chunk = r_pos[int'(r_idx)*CHUNK_W +: CHUNK_W];
`ifdef NEURON_TERNARY_EN
      if (r_state == NEG) begin
         w_chunk = r_neg[int'(r_idx)*CHUNK_W +: CHUNK_W];
      end
`endif
   end

   popcount18_unit u_pc (
      .i_bits  (w_chunk),
      .o_count (w_pc)
   );

   assign w_pc_ext   = $signed({{(ACC_W-4){1'b0}}, w_pc});
   assign w_acc_next = (r_state == NEG) ? (r_acc - w_pc_ext) : (r_acc + w_pc_ext);

   // Thresholds are zero-extended; +1 wins when both comparisons hold.
`ifdef NEURON_TERNARY_EN
   assign w_neg_lim = -$signed({1'b0, r_thr_neg});
   always_comb begin
      if (w_acc_next >= $signed({1'b0, r_thr_pos}))
         w_trit = TRIT_POS;
      else if (w_acc_next <= w_neg_lim)
         w_trit = TRIT_NEG;
      else
         w_trit = TRIT_ZERO;
   end
`else
   assign w_trit = (w_acc_next >= $signed({1'b0, r_thr_pos})) ? TRIT_POS : TRIT_ZERO;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_pos       <= '0;
         r_thr_pos   <= '0;
         r_acc       <= '0;
         r_idx       <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_out_sum   <= '0;
         r_out_trit  <= TRIT_ZERO;
`ifdef NEURON_TERNARY_EN
         r_neg       <= '0;
         r_thr_neg   <= '0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_pos      <= in_pos;
                  r_thr_pos  <= thr_pos;
`ifdef NEURON_TERNARY_EN
                  r_neg      <= in_neg;
                  r_thr_neg  <= thr_neg;
`endif
                  r_acc      <= '0;
                  r_idx      <= '0;
                  r_in_ready <= 1'b0;
                  r_state    <= POS;
               end
            end
            POS: begin
               r_acc <= w_acc_next;
               if (w_last) begin
                  r_idx <= '0;
`ifdef NEURON_TERNARY_EN
                  r_state <= NEG;
`else
                  r_out_sum   <= w_acc_next;
                  r_out_trit  <= w_trit;
                  r_out_valid <= 1'b1;
                  r_state     <= DONE;
`endif
               end else begin
                  r_idx <= r_idx + IDX_W'(1);
               end
            end
            NEG: begin
               r_acc <= w_acc_next;
               if (w_last) begin
                  r_idx       <= '0;
                  r_out_sum   <= w_acc_next;
                  r_out_trit  <= w_trit;
                  r_out_valid <= 1'b1;
                  r_state     <= DONE;
               end else begin
                  r_idx <= r_idx + IDX_W'(1);
               end
            end
            DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign out_sum   = r_out_sum;
   assign out_trit  = r_out_trit;

endmodule

// File: tb/tb_popcount_seq_neuron.sv
// Self-checking bench for popcount_seq_neuron (N_CHUNKS=4, F=72).
// Works with or without NEURON_TERNARY_EN; expectations follow the build.
module tb_popcount_seq_neuron;

   localparam int N  = 4;
   localparam int F  = 72;
   localparam int AW = 7;
`ifdef NEURON_TERNARY_EN
   localparam int EXP_LAT = 2 * N;
`else
   localparam int EXP_LAT = N;
`endif

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 in_valid;
   logic                 in_ready;
   logic [F-1:0]         in_pos;
   logic [F-1:0]         in_neg;
   logic [AW-1:0]        thr_pos;
   logic [AW-1:0]        thr_neg;
   logic                 out_valid;
   logic                 out_ready;
   logic signed [AW:0]   out_sum;
   logic [1:0]           out_trit;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   popcount_seq_neuron #(.N_CHUNKS(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_pos    (in_pos),
      .in_neg    (in_neg),
      .thr_pos   (thr_pos),
      .thr_neg   (thr_neg),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_trit  (out_trit)
   );

   typedef struct {
      logic [F-1:0]  pos;
      logic [F-1:0]  neg;
      logic [AW-1:0] tp;
      logic [AW-1:0] tn;
      int            exp_sum;
      logic [1:0]    exp_trit;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", nm, $signed(act), $signed(exp));
      end
   endtask

   // Reference: plain counting of ones and the threshold rule.
   function automatic void model(input logic [F-1:0] p, input logic [F-1:0] n,
                                 input logic [AW-1:0] tp, input logic [AW-1:0] tn,
                                 output int s, output logic [1:0] t);
`ifdef NEURON_TERNARY_EN
      s = $countones(p) - $countones(n);
      if (s >= int'(tp))       t = 2'b01;
      else if (s <= -int'(tn)) t = 2'b11;
      else                     t = 2'b00;
`else
      s = $countones(p);
      t = (s >= int'(tp)) ? 2'b01 : 2'b00;
`endif
   endfunction

   // Starts and ends just after a rising edge.
   task automatic run_vec(input logic [F-1:0] p, input logic [F-1:0] n,
                          input logic [AW-1:0] tp, input logic [AW-1:0] tn,
                          input int es, input logic [1:0] et, input string nm);
      int cyc;
      chk({nm, " in_ready_idle"}, 32'(in_ready), 32'd1);
      in_valid = 1'b1; in_pos = p; in_neg = n; thr_pos = tp; thr_neg = tn;
      @(posedge clk); #1;
      in_valid = 1'b0; in_pos = ~p; in_neg = ~n; thr_pos = ~tp; thr_neg = ~tn;
      cyc = 0;
      do begin
         @(posedge clk); #1;
         cyc++;
      end while (!out_valid && cyc < 60);
      chk({nm, " latency"}, 32'(cyc), 32'(EXP_LAT));
      chk({nm, " sum"}, 32'(out_sum), 32'(es));
      chk({nm, " trit"}, 32'(out_trit), 32'(et));
      chk({nm, " in_ready_busy"}, 32'(in_ready), 32'd0);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({nm, " valid_drop"}, 32'(out_valid), 32'd0);
      chk({nm, " ready_back"}, 32'(in_ready), 32'd1);
   endtask

   vec_t tbl[8];

   initial begin
      int            es;
      logic [1:0]    et;
      logic [F-1:0]  p, n, jp;
      logic [AW-1:0] tp, tn;
      logic          stable;
      logic signed [AW:0] held_sum;
      logic [1:0]    held_trit;

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      in_pos = '0; in_neg = '0; thr_pos = '0; thr_neg = '0;

`ifdef NEURON_TERNARY_EN
      tbl[0] = '{{F{1'b1}}, '0, 7'd72, 7'd0, 72, 2'b01};
      tbl[1] = '{'0, {F{1'b1}}, 7'd5, 7'd10, -72, 2'b11};
      tbl[2] = '{'0, {F{1'b1}}, 7'd5, 7'd73, -72, 2'b00};
      tbl[3] = '{72'h1F << 54, 72'h1F, 7'd0, 7'd0, 0, 2'b01};
      tbl[4] = '{72'h1F << 54, 72'h1F, 7'd1, 7'd0, 0, 2'b11};
      tbl[5] = '{{F{1'b1}}, {F{1'b1}}, 7'd1, 7'd1, 0, 2'b00};
      tbl[6] = '{72'h3FFFF, 72'h3 << 70, 7'd16, 7'd0, 16, 2'b01};
      tbl[7] = '{'0, 72'h7, 7'd1, 7'd3, -3, 2'b11};
`else
      tbl[0] = '{{F{1'b1}}, '0, 7'd72, 7'd0, 72, 2'b01};
      tbl[1] = '{'0, {F{1'b1}}, 7'd5, 7'd10, 0, 2'b00};
      tbl[2] = '{'0, {F{1'b1}}, 7'd5, 7'd73, 0, 2'b00};
      tbl[3] = '{72'h1F << 54, 72'h1F, 7'd0, 7'd0, 5, 2'b01};
      tbl[4] = '{72'h1F << 54, 72'h1F, 7'd1, 7'd0, 5, 2'b01};
      tbl[5] = '{{F{1'b1}}, {F{1'b1}}, 7'd1, 7'd1, 72, 2'b01};
      tbl[6] = '{72'h3FFFF, 72'h3 << 70, 7'd16, 7'd0, 18, 2'b01};
      tbl[7] = '{'0, 72'h7, 7'd1, 7'd3, 0, 2'b00};
`endif

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk("reset out_valid", 32'(out_valid), 32'd0);
      chk("reset in_ready", 32'(in_ready), 32'd1);
      chk("reset out_sum", 32'(out_sum), 32'd0);
      chk("reset out_trit", 32'(out_trit), 32'd0);
      @(posedge clk); #1;

      for (int i = 0; i < 8; i++) begin
         run_vec(tbl[i].pos, tbl[i].neg, tbl[i].tp, tbl[i].tn,
                 tbl[i].exp_sum, tbl[i].exp_trit, $sformatf("tbl%0d", i));
      end

      for (int i = 0; i < 30; i++) begin
         p = {8'($urandom), $urandom, $urandom};
         n = {8'($urandom), $urandom, $urandom};
         if (i % 3 == 0) p = p & {8'($urandom), $urandom, $urandom};
         if (i % 3 == 1) n = n & {8'($urandom), $urandom, $urandom};
         tp = AW'($urandom_range(0, 50));
         tn = AW'($urandom_range(0, 50));
         model(p, n, tp, tn, es, et);
         run_vec(p, n, tp, tn, es, et, $sformatf("rnd%0d", i));
      end

      // Backpressure: result held, in_valid ignored, then release.
      p = 72'hF0F0_1234_5678_9ABC_DE; n = 72'h0F_0000_00FF_0000_1111;
      tp = 7'd20; tn = 7'd4;
      model(p, n, tp, tn, es, et);
      in_valid = 1'b1; in_pos = p; in_neg = n; thr_pos = tp; thr_neg = tn;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (EXP_LAT) @(posedge clk);
      #1;
      chk("bp valid", 32'(out_valid), 32'd1);
      held_sum = out_sum; held_trit = out_trit;
      chk("bp sum", 32'(held_sum), 32'(es));
      jp = {F{1'b1}};
      in_valid = 1'b1; in_pos = jp; in_neg = '0; thr_pos = '0; thr_neg = '0;
      stable = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk); #1;
         if (!out_valid || out_sum !== held_sum || out_trit !== held_trit || in_ready)
            stable = 1'b0;
      end
      chk("bp stable", 32'(stable), 32'd1);
      p = 72'h00_0000_0000_0003_FFFF; n = 72'h00_0000_0000_0000_000F;
      tp = 7'd10; tn = 7'd10;
      model(p, n, tp, tn, es, et);
      in_pos = p; in_neg = n; thr_pos = tp; thr_neg = tn;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("bp release in_ready", 32'(in_ready), 32'd1);
      chk("bp release valid", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("bp next accepted", 32'(in_ready), 32'd0);
      repeat (EXP_LAT) @(posedge clk);
      #1;
      chk("bp next valid", 32'(out_valid), 32'd1);
      chk("bp next sum", 32'(out_sum), 32'(es));
      chk("bp next trit", 32'(out_trit), 32'(et));
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;

      // Reset mid-accumulation (second pass when ternary), then a clean vector.
      in_valid = 1'b1; in_pos = {F{1'b1}}; in_neg = 72'h1; thr_pos = 7'd3; thr_neg = 7'd3;
      @(posedge clk); #1;
      in_valid = 1'b0;
`ifdef NEURON_TERNARY_EN
      repeat (N + 1) @(posedge clk);
`else
      repeat (2) @(posedge clk);
`endif
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("midrst out_valid", 32'(out_valid), 32'd0);
      chk("midrst in_ready", 32'(in_ready), 32'd1);
      chk("midrst out_sum", 32'(out_sum), 32'd0);
      chk("midrst out_trit", 32'(out_trit), 32'd0);
      p = 72'h80_0000_0000_0000_0001; n = 72'h00_0000_0004_0000_0000;
      tp = 7'd2; tn = 7'd0;
      model(p, n, tp, tn, es, et);
      run_vec(p, n, tp, tn, es, et, "post_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
